// File: rtl/tt_vec_pkg.sv
// Shared types for the Tiny Tapeout vector sequencer: FSM states, vector layout, compare helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tt_vec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_FIN
    } state_t;

    localparam int UI_MSB   = 31;
    localparam int UI_LSB   = 24;
    localparam int UIO_MSB  = 23;
    localparam int UIO_LSB  = 16;
    localparam int EXP_MSB  = 15;
    localparam int EXP_LSB  = 8;
    localparam int MASK_MSB = 7;
    localparam int MASK_LSB = 0;

    typedef struct packed {
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] exp_uo;
        logic [7:0] mask_uo;
    } vec_t;

    // Only bits selected by the mask can fail; a zero mask always passes.
    function automatic logic vec_mismatch(input vec_t v, input logic [7:0] uo);
        return |((uo ^ v.exp_uo) & v.mask_uo);
    endfunction

endpackage

// File: rtl/tt_vec_mem.sv
// DEPTH x 32 vector store: synchronous write, asynchronous read on a shared address.
// Latency: write lands at the clock edge, read data follows the address combinationally.
// Backpressure: none; the caller gates wr_en.
module tt_vec_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wr_data,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/tt_vec_driver.sv
// On-chip vector sequencer: resets a tt_um DUT, replays stored vectors and checks uo_out.
// Latency: done at RST_CYCLES + N*(SETTLE+2) + 1 cycles after start (1 cycle for N=0).
// Backpressure: loads accepted only while ld_ready (idle); start while busy is dropped.
module tt_vec_driver
    import tt_vec_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 4,
    parameter int SETTLE     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   num_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(DEPTH)-1:0] fail_idx,
    output logic [7:0]               fail_cnt,
    output logic                     dut_ena,
    output logic                     dut_rst_n,
    output logic [7:0]               dut_ui_in,
    output logic [7:0]               dut_uio_in,
    input  logic [7:0]               dut_uo_out,
    input  logic [7:0]               dut_uio_out,
    input  logic [7:0]               dut_uio_oe
);

    localparam int AW   = $clog2(DEPTH);
    localparam int IW   = AW + 1;
    localparam int MAXC = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
    localparam int CW   = $clog2(MAXC) + 1;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [IW-1:0]   count, count_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    vec_t            cur_vec, cur_vec_nxt, rd_vec;
    logic            pad_en, pad_en_nxt;
    logic            ld_ready_nxt, busy_nxt, done_nxt, pass_nxt;
    logic            dut_ena_nxt, dut_rst_n_nxt;
    logic [AW-1:0]   fail_idx_nxt;
    logic [7:0]      fail_cnt_nxt;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_rdata;
    logic            mismatch;

    // Addressed by the look-ahead index so the next vector is ready as APPLY is entered.
    assign mem_addr = (state == S_IDLE) ? ld_addr : idx_nxt[AW-1:0];

    tt_vec_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (ld_valid && ld_ready),
        .addr    (mem_addr),
        .wr_data (ld_data),
        .rd_data (mem_rdata)
    );

    always_comb begin
        rd_vec         = '0;
        rd_vec.ui      = mem_rdata[UI_MSB:UI_LSB];
        rd_vec.uio     = mem_rdata[UIO_MSB:UIO_LSB];
        rd_vec.exp_uo  = mem_rdata[EXP_MSB:EXP_LSB];
        rd_vec.mask_uo = mem_rdata[MASK_MSB:MASK_LSB];
    end

    assign mismatch   = vec_mismatch(cur_vec, dut_uo_out);
    assign dut_ui_in  = cur_vec.ui;
    // Bidirectional pads the DUT is driving read back its own value.
    assign dut_uio_in = pad_en ? ((cur_vec.uio & ~dut_uio_oe) | (dut_uio_out & dut_uio_oe)) : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            count     <= '0;
            cnt       <= '0;
            cur_vec   <= '0;
            pad_en    <= 1'b0;
            ld_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_idx  <= '0;
            fail_cnt  <= '0;
            dut_ena   <= 1'b0;
            dut_rst_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            count     <= count_nxt;
            cnt       <= cnt_nxt;
            cur_vec   <= cur_vec_nxt;
            pad_en    <= pad_en_nxt;
            ld_ready  <= ld_ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            fail_idx  <= fail_idx_nxt;
            fail_cnt  <= fail_cnt_nxt;
            dut_ena   <= dut_ena_nxt;
            dut_rst_n <= dut_rst_n_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        count_nxt = count;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_vec == '0) begin
                        state_nxt = S_FIN;
                    end else begin
                        state_nxt = S_DRST;
                        idx_nxt   = '0;
                        count_nxt = (num_vec > IW'(DEPTH)) ? IW'(DEPTH) : num_vec;
                        cnt_nxt   = CW'(RST_CYCLES - 1);
                    end
                end
            end
            S_DRST: begin
                if (cnt == '0) state_nxt = S_APPLY;
                else           cnt_nxt   = cnt - CW'(1);
            end
            S_APPLY: begin
                state_nxt = S_SETTLE;
                cnt_nxt   = CW'(SETTLE - 1);
            end
            S_SETTLE: begin
                if (cnt == '0) state_nxt = S_CHECK;
                else           cnt_nxt   = cnt - CW'(1);
            end
            S_CHECK: begin
                if (idx + IW'(1) < count) begin
                    state_nxt = S_APPLY;
                    idx_nxt   = idx + IW'(1);
                end else begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs, keyed off the upcoming state.
    always_comb begin
        ld_ready_nxt  = (state_nxt == S_IDLE);
        busy_nxt      = (state_nxt != S_IDLE);
        done_nxt      = (state_nxt == S_FIN);
        pass_nxt      = pass;
        fail_idx_nxt  = fail_idx;
        fail_cnt_nxt  = fail_cnt;
        dut_ena_nxt   = dut_ena;
        dut_rst_n_nxt = dut_rst_n;
        cur_vec_nxt   = cur_vec;
        pad_en_nxt    = pad_en;
        if (state == S_IDLE && start) begin
            fail_idx_nxt = '0;
            fail_cnt_nxt = '0;
        end
        if (state == S_CHECK && mismatch) begin
            if (fail_cnt == 8'd0)  fail_idx_nxt = idx[AW-1:0];
            if (fail_cnt != 8'hFF) fail_cnt_nxt = fail_cnt + 8'd1;
        end
        if (state_nxt == S_DRST) begin
            dut_ena_nxt   = 1'b1;
            dut_rst_n_nxt = 1'b0;
            cur_vec_nxt   = '0;
            pad_en_nxt    = 1'b0;
        end
        if (state_nxt == S_APPLY) begin
            dut_rst_n_nxt = 1'b1;
            cur_vec_nxt   = rd_vec;
            pad_en_nxt    = 1'b1;
        end
        if (state_nxt == S_FIN) begin
            pass_nxt = (fail_cnt_nxt == 8'd0);
        end
    end

endmodule

// File: doc/tt_vec_driver.md
# tt_vec_driver

Hardware vector sequencer for the Tiny Tapeout pin interface: it drives `ui_in`/`uio_in` of a user project and checks `uo_out` against stored expectations. It is the in-silicon counterpart of the cocotb bench, used for on-chip self-test of `tt_um_*` designs and as a reusable harness in FPGA bring-up. Vectors are loaded into a small internal memory, then replayed after a DUT reset; the block reports pass/fail and the first failing index.

## Interface
Parameters:
- `DEPTH` = 16: number of vector slots; power of two, 2..256.
- `RST_CYCLES` = 4: cycles `dut_rst_n` is held low before the first vector; ≥1.
- `SETTLE` = 2: cycles between applying a vector and sampling outputs; ≥1.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `ld_valid`  in  1: vector write request.
- `ld_ready`  out  1: high only in IDLE.
- `ld_addr`  in  $clog2(DEPTH): slot index.
- `ld_data`  in  32: {ui[31:24], uio[23:16], exp_uo[15:8], mask_uo[7:0]}.
- `start`  in  1: one-cycle run request.
- `num_vec`  in  $clog2(DEPTH)+1: vectors to run, sampled on `start`.
- `busy`  out  1: run in progress.
- `done`  out  1: one-cycle pulse at end of run.
- `pass`  out  1: sticky result of last run.
- `fail_idx`  out  $clog2(DEPTH): first failing slot.
- `fail_cnt`  out  8: failing vectors, saturating at 255.
- `dut_ena`, `dut_rst_n`  out  1: to DUT `ena`/`rst_n`.
- `dut_ui_in`, `dut_uio_in`  out  8: to DUT.
- `dut_uo_out`, `dut_uio_out`, `dut_uio_oe`  in  8: from DUT.

## Operation
- Reset values: `ld_ready`=0 on the reset cycle then 1, `busy`=0, `done`=0, `pass`=0, `fail_idx`=0, `fail_cnt`=0, `dut_ena`=0, `dut_rst_n`=0, `dut_ui_in`=0, `dut_uio_in`=0. Vector memory is not cleared.
- Load: write when `ld_valid && ld_ready`; ignored otherwise (no stall or error).
- States: IDLE → DRST → APPLY → SETTLE → CHECK → (APPLY | FIN) → IDLE.
- IDLE: `start` with `num_vec`=0 → FIN directly (`pass`=1, `fail_cnt`=0). `num_vec` > DEPTH is clamped to DEPTH. Otherwise latch count, clear `fail_cnt`/`fail_idx`, go to DRST.
- DRST: `dut_ena`=1, `dut_rst_n`=0 for `RST_CYCLES` cycles; inputs driven 0.
- APPLY (1 cycle): `dut_rst_n`=1; drive `dut_ui_in`=ui and pad-resolved `dut_uio_in`: bit i = `dut_uio_out[i]` if `dut_uio_oe[i]`, else uio[i] (combinational from DUT outputs, re-evaluated every cycle while the vector is held).
- SETTLE: hold inputs `SETTLE` cycles.
- CHECK (1 cycle): mismatch if `(dut_uo_out ^ exp_uo) & mask_uo` ≠ 0. On first mismatch latch `fail_idx`; increment `fail_cnt` saturating. mask_uo=0 always passes. Next vector if index+1 < count, else FIN.
- FIN (1 cycle): `done`=1, `pass` = (`fail_cnt`==0), `dut_ena` stays 1, inputs hold the last vector; → IDLE.
- `start` while busy is ignored. `rst` mid-run aborts to IDLE with all outputs at reset values in the next cycle; no `done`.

## Timing
- All outputs registered, except the `dut_uio_in` pad-resolution mux.
- `start` at cycle 0 → DRST cycles 1..RST_CYCLES → first APPLY at cycle RST_CYCLES+1.
- Per-vector period = SETTLE+2 cycles; `done` pulses at cycle RST_CYCLES + N·(SETTLE+2) + 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive; `ld_ready` = !`busy`.
- Counter widths: vector index $clog2(DEPTH)+1 bits; settle/reset counter $clog2(max(RST_CYCLES,SETTLE))+1 bits.

## Structure
- Package `tt_vec_pkg`: FSM state enum, vector field slice constants (UI_MSB..MASK_LSB), `vec_t` packed struct.
- Sub-module `tt_vec_mem`: DEPTH×32 synchronous-write, asynchronous-read register file. Address is driven from the FSM index during the run and from `ld_addr` in IDLE.
- The pad-resolution mux stays in the top level.

## Test plan
- Loopback DUT (`uo_out`=`ui_in`). Load 3 vectors ui=0x11/0x22/0x33, exp equal, mask 0xFF; run N=3 → `done` at cycle 4+3·4+1=17, `pass`=1, `fail_cnt`=0.
- Same setup, vector 1 with exp=0x20 → `pass`=0, `fail_idx`=1, `fail_cnt`=1. Repeat with mask=0xF0 → `pass`=1.
- DUT driving `uio_oe`=0x0F, `uio_out`=0x05, vector uio=0xA0 → `dut_uio_in`=0xA5 during APPLY/SETTLE.
- `num_vec`=0 → `done` at cycle 1, `pass`=1, no DRST; `num_vec`=DEPTH+1 (5-bit) → exactly DEPTH vectors checked.
- Assert `rst` at cycle 8 of a run → cycle 9: `busy`=0, `dut_rst_n`=0, `dut_ena`=0, no `done` pulse; then a fresh `start` runs normally.
- `ld_valid` during a run with addr 0, data 0xFFFFFFFF → ignored; a rerun reproduces the original results.
